host_bfm_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges NUM_REQ host-BFM AXI-S TX request streams (per-PF/VF traffic generators) onto the single host TX link. A grant holds from the first beat of a packet until its tlast beat is accepted. The block sits between the per-function packet builders and the host AXI-S BFM driver. Each beat is stamped with the granted requester index for scoreboard attribution.

---
 rtl/host_bfm_types_pkg.sv | 13 +
 rtl/host_bfm_rr_pick.sv | 29 ++
 rtl/host_bfm_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_host_bfm_tx_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_bfm_types_pkg.sv
// rtl/host_bfm_types_pkg.sv - shared widths, types and index helper for the host BFM TX path
package host_bfm_types_pkg;
    localparam int TDATA_WIDTH      = 32;
    localparam int TUSER_WIDTH      = 8;
    localparam int HOST_BFM_MAX_REQ = 16;

    typedef enum logic {IDLE, LOCKED} arb_state_e;
    typedef logic [3:0] req_idx_t;

    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction
endpackage

// File: rtl/host_bfm_rr_pick.sv
// rtl/host_bfm_rr_pick.sv - combinational round-robin pick starting at rr_ptr
module host_bfm_rr_pick
    import host_bfm_types_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int idx;

    // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = wrap_idx(int'(rr_ptr) + k, NUM_REQ);
            if (req[idx]) begin
                sel = IDX_W'(idx);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/host_bfm_tx_arbiter.sv
// rtl/host_bfm_tx_arbiter.sv - packet-atomic round-robin TX arbiter; HOST_BFM_TX_ARB_STATS_EN adds counters
module host_bfm_tx_arbiter
    import host_bfm_types_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TDATA_WIDTH = host_bfm_types_pkg::TDATA_WIDTH,
    parameter int TUSER_WIDTH = host_bfm_types_pkg::TUSER_WIDTH,
    parameter int MAX_BEATS   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_tvalid,
    output logic [NUM_REQ-1:0]             req_tready,
    input  logic [NUM_REQ-1:0]             req_tlast,
    input  logic [NUM_REQ*TDATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ*TDATA_WIDTH/8-1:0] req_tkeep,
    input  logic [NUM_REQ*TUSER_WIDTH-1:0] req_tuser,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic                           out_tlast,
    output logic [TDATA_WIDTH-1:0]         out_tdata,
    output logic [TDATA_WIDTH/8-1:0]       out_tkeep,
    output logic [TUSER_WIDTH-1:0]         out_tuser,
    output logic [$clog2(NUM_REQ)-1:0]     out_src,
    output logic                           busy
`ifdef HOST_BFM_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          stats_pkt_cnt
`endif
);
    localparam int          IDX_W    = $clog2(NUM_REQ);
    localparam int          KEEP_W   = TDATA_WIDTH / 8;
    localparam bit          FORCE_EN = (MAX_BEATS > 0);
    localparam logic [15:0] FORCE_AT = FORCE_EN ? 16'(MAX_BEATS - 1) : 16'hFFFF;

    arb_state_e       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [15:0]      beat_cnt;
    logic [IDX_W-1:0] pick_sel;
    logic             pick_any;
    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic             force_last;
    logic             accept;

    host_bfm_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req_tvalid),
        .rr_ptr (rr_ptr),
        .sel    (pick_sel),
        .any    (pick_any)
    );

    always_comb begin
        sel        = (state == LOCKED) ? grant_idx : pick_sel;
        sel_valid  = (state == LOCKED) ? req_tvalid[grant_idx] : pick_any;
        force_last = FORCE_EN && (beat_cnt >= FORCE_AT);
    end

    // Outputs are forced quiet while rst is high, not just after the first edge.
    always_comb begin
        out_tvalid = !rst && sel_valid;
        out_tlast  = 1'b0;
        out_tdata  = '0;
        out_tkeep  = '0;
        out_tuser  = '0;
        out_src    = '0;
        req_tready = '0;
        if (out_tvalid) begin
            out_tlast = req_tlast[sel] || force_last;
            out_tdata = req_tdata[int'(sel)*TDATA_WIDTH +: TDATA_WIDTH];
            out_tkeep = req_tkeep[int'(sel)*KEEP_W +: KEEP_W];
            out_tuser = req_tuser[int'(sel)*TUSER_WIDTH +: TUSER_WIDTH];
            out_src   = sel;
        end
        if (!rst && (state == LOCKED || pick_any)) begin
            req_tready[sel] = out_tready;
        end
        busy   = !rst && (state == LOCKED);
        accept = out_tvalid && out_tready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
        end else if (accept) begin
            if (out_tlast) begin
                state    <= IDLE;
                rr_ptr   <= IDX_W'(wrap_idx(int'(sel) + 1, NUM_REQ));
                beat_cnt <= '0;
            end else if (state == IDLE) begin
                state     <= LOCKED;
                grant_idx <= sel;
                beat_cnt  <= 16'd1;
            end else if (beat_cnt != 16'hFFFF) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
        end
    end

`ifdef HOST_BFM_TX_ARB_STATS_EN
    logic [31:0] stall_cnt [NUM_REQ];
    logic [15:0] forced_release_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_pkt_cnt      <= '0;
            forced_release_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                stall_cnt[i] <= '0;
            end
        end else begin
            if (accept && out_tlast) begin
                stats_pkt_cnt[int'(sel)*32 +: 32] <= stats_pkt_cnt[int'(sel)*32 +: 32] + 32'd1;
            end
            if (out_tvalid && !out_tready) begin
                stall_cnt[sel] <= stall_cnt[sel] + 32'd1;
            end
            if (accept && force_last && !req_tlast[sel]) begin
                forced_release_cnt <= forced_release_cnt + 16'd1;
            end
        end
    end
`else
    // Statistics compiled out; arbitration is unaffected.
`endif
endmodule

// File: tb/tb_host_bfm_tx_arbiter.sv
// tb/tb_host_bfm_tx_arbiter.sv - scoreboard bench for host_bfm_tx_arbiter (MAX_BEATS=4)
module tb_host_bfm_tx_arbiter;
    import host_bfm_types_pkg::*;

    localparam int N  = 4;
    localparam int DW = TDATA_WIDTH;
    localparam int UW = TUSER_WIDTH;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_tvalid, req_tready, req_tlast;
    logic [N*DW-1:0] req_tdata;
    logic [N*KW-1:0] req_tkeep;
    logic [N*UW-1:0] req_tuser;
    logic            out_tvalid, out_tready, out_tlast;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic [UW-1:0]   out_tuser;
    logic [1:0]      out_src;
    logic            busy;
`ifdef HOST_BFM_TX_ARB_STATS_EN
    logic [N*32-1:0] stats_pkt_cnt;
`endif

    host_bfm_tx_arbiter #(.NUM_REQ(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .MAX_BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_tvalid (req_tvalid),
        .req_tready (req_tready),
        .req_tlast  (req_tlast),
        .req_tdata  (req_tdata),
        .req_tkeep  (req_tkeep),
        .req_tuser  (req_tuser),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tuser  (out_tuser),
        .out_src    (out_src),
        .busy       (busy)
`ifdef HOST_BFM_TX_ARB_STATS_EN
        ,
        .stats_pkt_cnt (stats_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          idle;
    } drv_beat_t;

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } exp_beat_t;

    drv_beat_t drv_q [N][$];
    exp_beat_t sb_q[$];
    int        acc_cyc[$];
    int        checks = 0;
    int        errors = 0;
    int        acc_count = 0;
    int        cyc = 0;
    bit        drv_en = 1'b0;
    bit        acc [N];
    bit        shown_idle [N];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk(input int i, input int t, input int b);
        return DW'({8'(i), 8'(t), 16'(b)});
    endfunction

    task automatic drive(input int i, input int t, input int b, input bit last);
        drv_beat_t d;
        d.data = mk(i, t, b);
        d.last = last;
        d.idle = 1'b0;
        drv_q[i].push_back(d);
    endtask

    task automatic gap(input int i);
        drv_beat_t d;
        d.data = '0;
        d.last = 1'b0;
        d.idle = 1'b1;
        drv_q[i].push_back(d);
    endtask

    task automatic expect_beat(input int i, input int t, input int b, input bit last);
        exp_beat_t e;
        e.src  = 2'(i);
        e.data = mk(i, t, b);
        e.last = last;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_acc(input int target, input int budget, output int bubbles);
        int n;
        n = 0;
        bubbles = 0;
        while (acc_count < target && n < budget) begin
            @(negedge clk);
            #1;
            if (busy && !out_tvalid) bubbles++;
            n++;
        end
        check("wait_acc", 64'(acc_count >= target), 64'd1);
    endtask

    // Per-requester AXI-S sources: hold each beat until its handshake.
    initial begin
        wait (drv_en);
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = req_tvalid[i] && req_tready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (drv_q[i].size() > 0 && (acc[i] || shown_idle[i])) void'(drv_q[i].pop_front());
                shown_idle[i] = 1'b0;
                if (drv_q[i].size() == 0) begin
                    req_tvalid[i] = 1'b0;
                end else if (drv_q[i][0].idle) begin
                    req_tvalid[i]  = 1'b0;
                    shown_idle[i]  = 1'b1;
                end else begin
                    req_tvalid[i]            = 1'b1;
                    req_tlast[i]             = drv_q[i][0].last;
                    req_tdata[i*DW +: DW]    = drv_q[i][0].data;
                    req_tuser[i*UW +: UW]    = drv_q[i][0].data[UW-1:0];
                end
            end
        end
    end

    // Monitor: every accepted output beat is popped and compared.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_tvalid && out_tready) begin
                acc_count++;
                acc_cyc.push_back(cyc);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected src=%0d data=%h last=%0b", out_src, out_tdata, out_tlast);
                end else begin
                    e = sb_q.pop_front();
                    if (out_src !== e.src || out_tdata !== e.data || out_tlast !== e.last ||
                        out_tuser !== e.data[UW-1:0] || out_tkeep !== {KW{1'b1}}) begin
                        errors++;
                        $display("FAIL beat: got src=%0d data=%h last=%0b user=%h keep=%h expected src=%0d data=%h last=%0b",
                                 out_src, out_tdata, out_tlast, out_tuser, out_tkeep, e.src, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        int bub;
        int base;
        rst        = 1'b1;
        out_tready = 1'b1;
        req_tvalid = '1;
        req_tlast  = '1;
        req_tdata  = '1;
        req_tkeep  = '1;
        req_tuser  = '1;
        repeat (2) @(negedge clk);
        check("rst_out_tvalid", 64'(out_tvalid), 64'd0);
        check("rst_req_tready", 64'(req_tready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_tdata", 64'(out_tdata), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_tvalid = '0;
        req_tlast  = '0;
        req_tdata  = '0;
        req_tuser  = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_out_tvalid", 64'(out_tvalid), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_req_tready", 64'(req_tready), 64'd0);
        end
        drv_en = 1'b1;

        // Two contending 3-beat packets: req0 then req2 back to back.
        @(posedge clk);
        #2;
        for (int b = 0; b < 3; b++) begin
            drive(0, 1, b, b == 2);
            drive(2, 1, b, b == 2);
        end
        for (int b = 0; b < 3; b++) expect_beat(0, 1, b, b == 2);
        for (int b = 0; b < 3; b++) expect_beat(2, 1, b, b == 2);
        base = acc_cyc.size();
        wait_acc(6, 100, bub);
        if (acc_cyc.size() >= base + 6) check("t1_span", 64'(acc_cyc[base+5] - acc_cyc[base]), 64'd5);

        // Granted req1 bubbles for 2 cycles; req3 must wait for its tlast.
        @(posedge clk);
        #2;
        drive(1, 2, 0, 1'b0);
        drive(1, 2, 1, 1'b0);
        gap(1);
        gap(1);
        drive(1, 2, 2, 1'b1);
        for (int b = 0; b < 3; b++) expect_beat(1, 2, b, b == 2);
        repeat (2) @(posedge clk);
        #2;
        drive(3, 2, 0, 1'b1);
        expect_beat(3, 2, 0, 1'b1);
        wait_acc(10, 100, bub);
        check("t2_bubbles", 64'(bub), 64'd2);

        // All four streaming single-beat packets: strict rotation, one per cycle.
        @(posedge clk);
        #2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                drive(i, 3, r, 1'b1);
                expect_beat(i, 3, r, 1'b1);
            end
        end
        base = acc_cyc.size();
        wait_acc(18, 100, bub);
        if (acc_cyc.size() >= base + 8) check("t3_span", 64'(acc_cyc[base+7] - acc_cyc[base]), 64'd7);

        // Downstream stall on req2's second beat.
        @(posedge clk);
        #2;
        for (int b = 0; b < 3; b++) begin
            drive(2, 4, b, b == 2);
            expect_beat(2, 4, b, b == 2);
        end
        wait_acc(19, 100, bub);
        @(posedge clk);
        #1;
        out_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_tdata", 64'(out_tdata), 64'(mk(2, 4, 1)));
            check("stall_req_tready", 64'(req_tready), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_src", 64'(out_src), 64'd2);
        end
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        wait_acc(21, 100, bub);

        // Runaway packet: 4th beat gets a forced tlast, then pending req1 wins.
        @(posedge clk);
        #2;
        for (int b = 0; b < 6; b++) drive(0, 5, b, 1'b0);
        for (int b = 0; b < 4; b++) expect_beat(0, 5, b, b == 3);
        repeat (2) @(posedge clk);
        #2;
        drive(1, 5, 0, 1'b1);
        expect_beat(1, 5, 0, 1'b1);
        expect_beat(0, 5, 4, 1'b0);
        expect_beat(0, 5, 5, 1'b0);
        wait_acc(28, 200, bub);
        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("total_beats", 64'(acc_count), 64'd28);
        check("t5_still_locked", 64'(busy), 64'd1);
`ifdef HOST_BFM_TX_ARB_STATS_EN
        check("forced_release", 64'(dut.forced_release_cnt), 64'd1);
        check("pkt_cnt_req2", 64'(stats_pkt_cnt[2*32 +: 32]), 64'd4);
        check("stall_cnt_req2", 64'(dut.stall_cnt[2]), 64'd5);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
